// File: rtl/armleocpu_icache_responder.sv
// Instruction-side cache responder: direct-mapped, one word per line, physically addressed.
// Refills misses over a single-outstanding read channel and performs reset/flush invalidation sweeps.
module armleocpu_icache_responder #(
  parameter int LANES_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  c_cmd,
  input  logic [31:0] c_address,
  output logic [3:0]  c_response,
  output logic [31:0] c_load_data,
  output logic        c_reset_done,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp
);

  localparam int LANES = 1 << LANES_W;
  localparam int TAG_W = 30 - LANES_W;
  localparam logic [LANES_W-1:0] CNT_LAST = {LANES_W{1'b1}};
  localparam logic [LANES_W-1:0] CNT_ONE  = LANES_W'(1);

  localparam logic [3:0] CMD_EXECUTE   = 4'd1;
  localparam logic [3:0] CMD_FLUSH_ALL = 4'd4;

  localparam logic [3:0] RESP_IDLE        = 4'd0;
  localparam logic [3:0] RESP_DONE        = 4'd1;
  localparam logic [3:0] RESP_WAIT        = 4'd2;
  localparam logic [3:0] RESP_MISSALIGNED = 4'd3;
  localparam logic [3:0] RESP_ACCESSFAULT = 4'd5;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_ACTIVE,
    ST_MISS_AR,
    ST_MISS_R,
    ST_FLUSH
  } state_t;

  state_t             state_q, state_d;
  logic [LANES_W-1:0] cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         resp_q, resp_d;
  logic [31:0]        load_data_q, load_data_d;
  logic               reset_done_q, reset_done_d;
  logic               arvalid_q, arvalid_d;

  logic [LANES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q [LANES];
  logic [31:0]        data_q [LANES];

  logic [LANES_W-1:0] req_idx_s;
  logic [TAG_W-1:0]   req_tag_s;
  logic [LANES_W-1:0] fill_idx_s;
  logic               hit_s;
  logic               clear_en_s;
  logic               fill_en_s;

  assign req_idx_s  = c_address[LANES_W+1:2];
  assign req_tag_s  = c_address[31:LANES_W+2];
  assign fill_idx_s = addr_q[LANES_W+1:2];
  assign hit_s      = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);

  assign c_response   = resp_q;
  assign c_load_data  = load_data_q;
  assign c_reset_done = reset_done_q;
  assign m_araddr     = addr_q;
  assign m_arvalid    = arvalid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RESET;
      cnt_q        <= '0;
      addr_q       <= 32'd0;
      resp_q       <= RESP_IDLE;
      load_data_q  <= 32'd0;
      reset_done_q <= 1'b0;
      arvalid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      resp_q       <= resp_d;
      load_data_q  <= load_data_d;
      reset_done_q <= reset_done_d;
      arvalid_q    <= arvalid_d;
    end
  end

  // Sweeps clear one valid bit per cycle; a successful refill sets the latched line.
  always_ff @(posedge clk) begin
    if (clear_en_s) begin
      valid_q[cnt_q] <= 1'b0;
    end else if (rst_n && fill_en_s) begin
      valid_q[fill_idx_s] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && fill_en_s) begin
      tag_q[fill_idx_s]  <= addr_q[31:LANES_W+2];
      data_q[fill_idx_s] <= m_rdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    resp_d       = RESP_IDLE;
    load_data_d  = load_data_q;
    // Follows the registered state, so it rises the cycle after ACTIVE is entered.
    reset_done_d = 1'b1;
    arvalid_d    = arvalid_q;
    clear_en_s   = 1'b0;
    fill_en_s    = 1'b0;

    case (state_q)
      ST_RESET: begin
        reset_done_d = 1'b0;
        clear_en_s   = 1'b1;
        cnt_d        = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_RESET;
        end
      end

      ST_ACTIVE: begin
        case (c_cmd)
          CMD_EXECUTE: begin
            if (c_address[1:0] != 2'b00) begin
              resp_d = RESP_MISSALIGNED;
            end else if (hit_s) begin
              resp_d      = RESP_DONE;
              load_data_d = data_q[req_idx_s];
            end else begin
              addr_d    = {c_address[31:2], 2'b00};
              arvalid_d = 1'b1;
              state_d   = ST_MISS_AR;
              resp_d    = RESP_WAIT;
            end
          end
          CMD_FLUSH_ALL: begin
            cnt_d   = '0;
            state_d = ST_FLUSH;
            resp_d  = RESP_WAIT;
          end
          default: begin
            resp_d = RESP_IDLE;
          end
        endcase
      end

      ST_MISS_AR: begin
        resp_d = RESP_WAIT;
        if (m_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_MISS_R;
        end else begin
          arvalid_d = 1'b1;
        end
      end

      ST_MISS_R: begin
        if (m_rvalid) begin
          state_d = ST_ACTIVE;
          if (m_rresp == 2'b00) begin
            fill_en_s   = 1'b1;
            resp_d      = RESP_DONE;
            load_data_d = m_rdata;
          end else begin
            resp_d = RESP_ACCESSFAULT;
          end
        end else begin
          resp_d = RESP_WAIT;
        end
      end

      ST_FLUSH: begin
        clear_en_s = 1'b1;
        cnt_d      = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_ACTIVE;
          resp_d  = RESP_DONE;
        end else begin
          resp_d = RESP_WAIT;
        end
      end

      default: begin
        state_d      = ST_RESET;
        cnt_d        = '0;
        reset_done_d = 1'b0;
        arvalid_d    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_armleocpu_icache_responder.sv
// Scoreboard bench for armleocpu_icache_responder: directed fetches, refills, errors, flush and resets.
module tb_armleocpu_icache_responder;

  localparam logic [3:0] CMD_NONE      = 4'd0;
  localparam logic [3:0] CMD_EXECUTE   = 4'd1;
  localparam logic [3:0] CMD_FLUSH_ALL = 4'd4;

  localparam logic [3:0] RESP_IDLE        = 4'd0;
  localparam logic [3:0] RESP_DONE        = 4'd1;
  localparam logic [3:0] RESP_WAIT        = 4'd2;
  localparam logic [3:0] RESP_MISSALIGNED = 4'd3;
  localparam logic [3:0] RESP_ACCESSFAULT = 4'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  c_cmd;
  logic [31:0] c_address;
  logic [3:0]  c_response;
  logic [31:0] c_load_data;
  logic        c_reset_done;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;

  armleocpu_icache_responder #(.LANES_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_cmd(c_cmd), .c_address(c_address),
    .c_response(c_response), .c_load_data(c_load_data), .c_reset_done(c_reset_done),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  resp;
    logic [31:0] data;
    int          cyc;
    bit          chk_data;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] resp, input logic [31:0] data, input int at, input bit chk);
    exp_t e;
    e.resp = resp; e.data = data; e.cyc = at; e.chk_data = chk;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every terminal response must match the oldest expected entry, in the expected cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && c_response !== RESP_IDLE && c_response !== RESP_WAIT) begin
      if (sb_q.size() == 0) begin
        check("unexpected_response", {28'd0, c_response}, {28'd0, RESP_IDLE});
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_code", {28'd0, c_response}, {28'd0, e.resp});
        check("resp_cycle", 32'(cyc), 32'(e.cyc));
        if (e.chk_data) check("load_data", c_load_data, e.data);
      end
    end
  end

  task automatic do_reset(input string tag);
    int n;
    bit idle_ok;
    rst_n = 1'b0;
    c_cmd = CMD_NONE; m_arready = 1'b0; m_rvalid = 1'b0;
    tick();
    check({tag, "_resp_idle"}, {28'd0, c_response}, {28'd0, RESP_IDLE});
    check({tag, "_arvalid"}, {31'd0, m_arvalid}, 32'd0);
    check({tag, "_load_data"}, c_load_data, 32'd0);
    check({tag, "_reset_done_low"}, {31'd0, c_reset_done}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    idle_ok = 1'b1;
    while (c_reset_done === 1'b0 && n < 200) begin
      if (c_response !== RESP_IDLE) idle_ok = 1'b0;
      n++;
      tick();
    end
    check({tag, "_sweep_len"}, 32'(n), 32'd65);
    check({tag, "_sweep_idle"}, {31'd0, idle_ok}, 32'd1);
    check({tag, "_reset_done"}, {31'd0, c_reset_done}, 32'd1);
  endtask

  // Miss with arready in N+1 and rvalid in N+3, so the result lands in N+4.
  task automatic do_miss(input logic [31:0] addr, input logic [31:0] rdata, input logic [1:0] rresp,
                         input logic [3:0] exp_resp, input string tag);
    push_exp(exp_resp, rdata, cyc + 4, exp_resp == RESP_DONE);
    c_cmd = CMD_EXECUTE; c_address = addr;
    tick();
    c_cmd = CMD_NONE;
    check({tag, "_wait"}, {28'd0, c_response}, {28'd0, RESP_WAIT});
    check({tag, "_arvalid"}, {31'd0, m_arvalid}, 32'd1);
    check({tag, "_araddr"}, m_araddr, addr);
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    check({tag, "_arvalid_drop"}, {31'd0, m_arvalid}, 32'd0);
    tick();
    m_rvalid = 1'b1; m_rdata = rdata; m_rresp = rresp;
    tick();
    m_rvalid = 1'b0; m_rdata = 32'd0; m_rresp = 2'd0;
    tick();
  endtask

  task automatic do_hit(input logic [31:0] addr, input logic [31:0] data, input string tag);
    push_exp(RESP_DONE, data, cyc + 1, 1'b1);
    c_cmd = CMD_EXECUTE; c_address = addr;
    tick();
    c_cmd = CMD_NONE;
    check({tag, "_no_arvalid"}, {31'd0, m_arvalid}, 32'd0);
    tick();
  endtask

  initial begin
    logic [31:0] bb_addr [4];
    logic [31:0] bb_data [4];
    bit          ok;
    int          n0;

    rst_n = 1'b0; c_cmd = CMD_NONE; c_address = 32'd0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'd0; m_rresp = 2'd0;

    do_reset("por");

    do_miss(32'h0000_2000, 32'h0000_0013, 2'd0, RESP_DONE, "cold_miss");
    do_hit(32'h0000_2000, 32'h0000_0013, "rehit");
    do_miss(32'h0000_2004, 32'h0010_0093, 2'd0, RESP_DONE, "fill_2004");

    // Back-to-back hits, one command per cycle.
    bb_addr[0] = 32'h0000_2000; bb_data[0] = 32'h0000_0013;
    bb_addr[1] = 32'h0000_2004; bb_data[1] = 32'h0010_0093;
    bb_addr[2] = 32'h0000_2000; bb_data[2] = 32'h0000_0013;
    bb_addr[3] = 32'h0000_2004; bb_data[3] = 32'h0010_0093;
    for (int i = 0; i < 4; i++) begin
      push_exp(RESP_DONE, bb_data[i], cyc + 1, 1'b1);
      c_cmd = CMD_EXECUTE; c_address = bb_addr[i];
      tick();
    end
    c_cmd = CMD_NONE;
    tick();

    // 0x2100 shares the index of 0x2000.
    do_miss(32'h0000_2100, 32'hAAAA_5555, 2'd0, RESP_DONE, "conflict");
    do_miss(32'h0000_2000, 32'h0000_0013, 2'd0, RESP_DONE, "evicted");
    do_hit(32'h0000_2000, 32'h0000_0013, "refilled_hit");

    push_exp(RESP_MISSALIGNED, 32'd0, cyc + 1, 1'b0);
    c_cmd = CMD_EXECUTE; c_address = 32'h0000_2002;
    tick();
    c_cmd = CMD_NONE;
    check("misaligned_no_arvalid", {31'd0, m_arvalid}, 32'd0);
    tick();
    check("misaligned_one_cycle", {28'd0, c_response}, {28'd0, RESP_IDLE});

    do_miss(32'h0000_3000, 32'hDEAD_BEEF, 2'd2, RESP_ACCESSFAULT, "fault");
    do_miss(32'h0000_3000, 32'h1234_5678, 2'd0, RESP_DONE, "fault_refetch");
    do_hit(32'h0000_3000, 32'h1234_5678, "fault_refetch_hit");

    // Flush: 64 WAIT cycles, DONE in N+65.
    n0 = cyc;
    push_exp(RESP_DONE, 32'd0, n0 + 65, 1'b0);
    c_cmd = CMD_FLUSH_ALL; c_address = 32'd0;
    tick();
    c_cmd = CMD_NONE;
    ok = 1'b1;
    repeat (64) begin
      if (c_response !== RESP_WAIT) ok = 1'b0;
      tick();
    end
    check("flush_wait", {31'd0, ok}, 32'd1);
    tick();
    check("flush_done_one_cycle", {28'd0, c_response}, {28'd0, RESP_IDLE});
    do_miss(32'h0000_2000, 32'h0000_0013, 2'd0, RESP_DONE, "post_flush");

    // Reset while a refill is outstanding in MISS_R.
    c_cmd = CMD_EXECUTE; c_address = 32'h0000_4000;
    tick();
    c_cmd = CMD_NONE;
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    check("midmiss_pre_wait", {28'd0, c_response}, {28'd0, RESP_WAIT});
    do_reset("midmiss");
    do_miss(32'h0000_2000, 32'h0000_0077, 2'd0, RESP_DONE, "post_reset");

    repeat (3) tick();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
